// File: rtl/axi4_write_burst_slave.sv
// AXI4 write-channel slave: one AW transaction at a time, FIXED/INCR/WRAP bursts,
// registered byte-lane writes to an SRAM-style port, sticky SLVERR reporting on B.
module axi4_write_burst_slave #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_BYTES = 4096,
  localparam int unsigned STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;
  typedef enum logic [1:0] {B_FIXED, B_INCR, B_WRAP, B_RSVD} burst_e;

  localparam int unsigned     AW1      = ADDR_W + 1;
  localparam logic [2:0]      MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [ADDR_W:0] MEM_LIM  = AW1'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  burst_e              burst_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, cnt_q;
  logic [2:0]          size_q;
  logic                err_q, supp_q;

  logic                awready_q, wready_q, bvalid_q, mem_we_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;

  logic                aw_hs, w_hs, b_hs;
  logic                aw_badlen, aw_supp, aw_err;
  burst_e              aw_burst_eff;
  logic [ADDR_W-1:0]   aw_step, step, wrap_mask;
  logic                last_beat, beat_oor, beat_err;

  always_comb begin
    aw_hs     = awvalid && awready_q;
    w_hs      = wvalid && wready_q;
    b_hs      = bvalid_q && bready;

    aw_step   = A_ONE << awsize;
    aw_badlen = !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    aw_supp   = (awsize > MAX_SIZE) || (awburst == B_RSVD);
    aw_err    = aw_supp ||
                ((awburst == B_WRAP) && (aw_badlen || ((awaddr & (aw_step - A_ONE)) != '0)));
    // Reserved bursts and WRAP with an illegal length are carried out as INCR.
    aw_burst_eff = ((awburst == B_RSVD) || ((awburst == B_WRAP) && aw_badlen))
                   ? B_INCR : burst_e'(awburst);

    step      = A_ONE << size_q;
    wrap_mask = ((ADDR_W'(len_q) + A_ONE) << size_q) - A_ONE;
    unique case (burst_q)
      B_FIXED: addr_d = addr_q;
      B_WRAP:  addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_d = addr_q + step;
    endcase

    last_beat = (cnt_q == len_q);
    beat_oor  = ({1'b0, addr_q} >= MEM_LIM);
    beat_err  = beat_oor || (wlast != last_beat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      burst_q     <= B_FIXED;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
      supp_q      <= 1'b0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (aw_hs) begin
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= aw_burst_eff;
            err_q     <= aw_err;
            supp_q    <= aw_supp;
            cnt_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            mem_we_q    <= !supp_q && !beat_oor;
            mem_addr_q  <= addr_q & ~(step - A_ONE);
            mem_wdata_q <= wdata;
            mem_wstrb_q <= wstrb;
            addr_q      <= addr_d;
            err_q       <= err_q || beat_err;
            // The beat count alone ends the burst; wlast only feeds the error flag.
            if (last_beat) begin
              cnt_q    <= '0;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || beat_err) ? 2'b10 : 2'b00;
              state_q  <= S_RESP;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_RESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi4_write_burst_slave.sv
// Scoreboard bench for axi4_write_burst_slave: a burst-level reference model queues
// expected memory writes and B responses; a monitor pops them as the DUT emits them.
module tb_axi4_write_burst_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, mem_we;
  logic [3:0]  awid, bid, wstrb, mem_wstrb;
  logic [31:0] awaddr, wdata, mem_addr, mem_wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit use_fix = 1'b0;
  logic [31:0] fix_data = '0;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  typedef struct { logic [3:0] id; logic [1:0] r; } b_t;
  wr_t wq[$];
  b_t  bq[$];
  wr_t mw;
  b_t  mb;

  axi4_write_burst_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bid"}, bid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
  endtask

  // Monitor: every emitted write and every B handshake is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL mem_we_unexpected actual_addr=%0h required=none", mem_addr);
        end else begin
          mw = wq.pop_front();
          if (mem_addr !== mw.a || mem_wdata !== mw.d || mem_wstrb !== mw.s) begin
            errors++;
            $display("FAIL mem_write actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                     mem_addr, mem_wdata, mem_wstrb, mw.a, mw.d, mw.s);
          end
        end
      end
      if (bvalid && bready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected actual_bid=%0h required=none", bid);
        end else begin
          mb = bq.pop_front();
          if (bid !== mb.id || bresp !== mb.r) begin
            errors++;
            $display("FAIL b_resp actual=%0h/%0h required=%0h/%0h", bid, bresp, mb.id, mb.r);
          end
        end
      end
    end
  end

  task automatic wait_hs(input bit on_w, output bit ok, output int hs_cyc);
    int t = 0;
    bit hs;
    do begin
      @(negedge clk);
      hs = on_w ? wready : awready;
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 50);
    ok = hs;
  endtask

  // bad_beat: index whose wlast is inverted; abort_at: assert reset after that many beats.
  task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                         input int gap, input int bdelay, input int abort_at,
                         input bit w_early, input bit hold_aw, input bit chk_lat);
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    int unsigned nb, step, c;
    logic [1:0]  eff;
    logic [31:0] a, d, lower;
    logic [3:0]  s;
    logic [1:0]  exp_r;
    bit badlen, supp, err, ok;
    int aw_cyc, dummy, t;

    nb     = int'(len) + 1;
    step   = 1 << size;
    c      = nb * step;
    badlen = !(len == 1 || len == 3 || len == 7 || len == 15);
    eff    = (burst == 2'b11 || (burst == 2'b10 && badlen)) ? 2'b01 : burst;
    supp   = (size > 2) || (burst == 2'b11);
    err    = (burst == 2'b11) || (burst == 2'b10 && badlen) ||
             (burst == 2'b10 && (addr % step) != 0) || (size > 2) || (bad_beat >= 0);
    for (int i = 0; i < int'(nb); i++) begin
      d = use_fix ? fix_data : $urandom;
      s = use_fix ? 4'hF : 4'($urandom);
      dq.push_back(d);
      sq.push_back(s);
      if (eff == 2'b00)      a = addr;
      else if (eff == 2'b01) a = addr + i * step;
      else begin
        lower = addr - (addr % c);
        a = lower + ((addr + i * step) % c);
      end
      if (a >= 4096) err = 1'b1;
      else if (!supp) wq.push_back('{a - (a % step), d, s});
    end
    exp_r = err ? 2'b10 : 2'b00;
    if (abort_at < 0) bq.push_back('{id, exp_r});

    if (w_early) begin
      wvalid = 1'b1; wdata = dq[0]; wstrb = sq[0]; wlast = (nb == 1);
      repeat (3) begin
        @(negedge clk);
        chk("wready_before_aw", wready, 0);
        @(posedge clk);
        #1;
      end
    end

    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    wait_hs(1'b0, ok, aw_cyc);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL aw_timeout actual=no_awready required=awready");
      awvalid = 1'b0;
      return;
    end
    awvalid = 1'b0;

    for (int i = 0; i < int'(nb); i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      wvalid = 1'b1; wdata = dq[i]; wstrb = sq[i];
      wlast  = (i == int'(nb) - 1) ^ (i == bad_beat);
      wait_hs(1'b1, ok, dummy);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL w_timeout actual=no_wready required=wready");
        wvalid = 1'b0;
        return;
      end
      if (i + 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_rst("mid_burst_reset");
        wq.delete();
        bq.delete();
        wvalid = 1'b0; wlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bvalid_in_reset", bvalid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("bvalid_after_reset", bvalid, 0);
        chk("awready_after_reset", awready, 1);
        @(posedge clk);
        #1;
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;

    if (hold_aw) begin
      awvalid = 1'b1; awid = ~id; awaddr = 32'h0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bvalid && t < 100);
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout actual=no_bvalid required=bvalid");
      awvalid = 1'b0;
      return;
    end
    if (chk_lat) begin
      chk("aw_to_b_latency", cyc - aw_cyc, 2);
      chk("last_we_with_bvalid", mem_we, 1);
    end
    for (int k = 0; k < bdelay; k++) begin
      chk("stall_bvalid", bvalid, 1);
      chk("stall_bid", bid, id);
      chk("stall_bresp", bresp, exp_r);
      chk("stall_awready", awready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    chk("awready_after_b", awready, 1);
    awvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rsize;
    logic [7:0]  rlen;
    logic [31:0] raddr;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_rst("post_reset");
    @(posedge clk);
    #1;

    use_fix = 1'b1; fix_data = 32'hA5A5A5A5;
    run_txn(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, -1, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    use_fix = 1'b0;
    run_txn(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, -1, 1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, -1, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd4, 32'h20, 8'd2, 3'd2, 2'b00, -1, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd5, 32'h200, 8'd3, 3'd2, 2'b01, 1, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd6, 32'hFFC, 8'd1, 3'd2, 2'b01, -1, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd7, 32'h40, 8'd1, 3'd3, 2'b01, -1, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(4'd8, 32'h80, 8'd1, 3'd2, 2'b01, -1, 0, 5, -1, 1'b1, 1'b1, 1'b0);
    run_txn(4'd9, 32'h300, 8'd7, 3'd2, 2'b01, -1, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    run_txn(4'd10, 32'h300, 8'd7, 3'd2, 2'b01, -1, 0, 0, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rsize = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rlen  = ($urandom_range(0, 3) == 0) ? 8'd15 : 8'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(4032, 4095))
                                          : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~((32'd1 << rsize) - 32'd1);
      run_txn(4'($urandom), raddr, rlen, rsize, 2'($urandom),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(rlen))) : -1,
              2, $urandom_range(0, 3), -1, 1'b0, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("writes_drained", wq.size(), 0);
    chk("responses_drained", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_write_burst_slave.md
Name: axi4_write_burst_slave

Overview:
Parametrised AXI4 write-channel slave that generalises the single-beat write FSM to full bursts (FIXED/INCR/WRAP), IDs, byte strobes and error responses. It accepts one AW transaction at a time and converts each accepted W beat into a registered byte-lane write on a simple SRAM-style port. It returns a B response carrying the transaction ID and an OKAY/SLVERR code. It sits between the AXI interconnect and on-chip memory or register banks.

Parameters:
ADDR_W, 32, AXI address width in bits
DATA_W, 32, data width in bits (8/16/32/64/128); STRB_W = DATA_W/8
ID_W, 4, AWID/BID width
MEM_BYTES, 4096, size of the addressable window in bytes; addresses >= MEM_BYTES are out of range

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awvalid  in  1  AW valid
awready  out  1  AW ready
awid  in  ID_W  transaction ID
awaddr  in  ADDR_W  start byte address
awlen  in  8  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
wvalid  in  1  W valid
wready  out  1  W ready
wdata  in  DATA_W  write data
wstrb  in  STRB_W  byte enables
wlast  in  1  last beat marker
bvalid  out  1  B valid
bready  in  1  B ready
bid  out  ID_W  response ID
bresp  out  2  00 OKAY, 10 SLVERR
mem_we  out  1  memory write strobe, one cycle
mem_addr  out  ADDR_W  beat-aligned byte address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  STRB_W  byte enables

Behaviour:
- Reset and clock: rst_n asynchronous, active-low; clock clk. During and after reset: state IDLE, awready=1, wready=0, bvalid=0, bid=0, bresp=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, beat counter=0, error flag=0. Reset asserted mid-burst or mid-response drops the transaction; no B is issued.
- States:
  - IDLE: awready=1.
    - On awvalid&&awready: latch id, addr, len, size and burst; clear the error flag; go to DATA.
    - W is never accepted in IDLE. Data arriving before the address waits.
  - DATA: wready=1, awready=0. Each wvalid&&wready is one beat.
    - Beat count reaches awlen+1: go to RESP. The count alone ends the burst.
  - RESP: bvalid=1. bid and bresp stay stable until bready.
    - On bvalid&&bready: go to IDLE. awready is 1 the following cycle.
- Memory write timing: on each W handshake, mem_we=1 in the next cycle. mem_addr, mem_wdata and mem_wstrb are registered from the current beat; mem_addr is aligned down to 1<<size.
  - The write of a suppressed beat is dropped (mem_we=0).
  - Beats with wstrb=0 still pulse mem_we.
- Response latency: bvalid rises the cycle after the final W handshake, in the same cycle as the last mem_we. Minimum AW-to-B latency for len=0 with W valid throughout: AW accepted at cycle 0, W at cycle 1, bvalid at cycle 2.
- Address generation. Beat address for the next beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size); ADDR_W wrap-around ignored.
  - WRAP: container = (len+1)<<size. Next address = (addr & ~(container-1)) | ((addr + (1<<size)) & (container-1)).
- SLVERR conditions. The error flag is set, sticky for the transaction, when any of the following occurs:
  - awburst=11, treated as INCR.
  - WRAP with awlen not in {1,3,7,15}, treated as INCR.
  - WRAP with a start address unaligned to 1<<size.
  - (1<<awsize) > STRB_W.
  - wlast=1 on a non-final beat, or wlast=0 on the final beat.
  - Any beat address >= MEM_BYTES.
- Write suppression:
  - awsize too large or awburst=11: the whole transaction is suppressed.
  - Out-of-range: only that beat is suppressed.
  - wlast mismatch: writes proceed.
- bresp = SLVERR if the error flag is set, else OKAY.
- Back-pressure: wready stays 1 throughout DATA; wvalid gaps are allowed.
- Throughput: single outstanding transaction. awvalid held during DATA/RESP is accepted only after return to IDLE.

Test Plan:
- Single beat: AW id=3 addr=0x10 len=0 size=2 INCR, W data=0xA5A5A5A5 strb=F wlast=1 -> one mem_we with addr 0x10, data 0xA5A5A5A5; bvalid 2 cycles after AW, bid=3, bresp=00.
- INCR len=3 size=2 from 0x100, wvalid toggling every other cycle -> mem_addr 0x100, 0x104, 0x108, 0x10C; exactly 4 mem_we; bresp OKAY.
- WRAP len=3 size=2 from 0x38 -> mem_addr 0x38, 0x3C, 0x30, 0x34; FIXED len=2 at 0x20 -> 0x20 three times.
- Errors, one case each:
  - wlast=1 on beat 1 of a len=3 burst -> 4 writes, bresp=10.
  - addr=0xFFC len=1 with MEM_BYTES=4096 -> write at 0xFFC only, bresp=10.
  - awsize=3 with DATA_W=32 -> no mem_we, bresp=10.
- bready held low 5 cycles -> bvalid, bid, bresp stable; a second awvalid is not accepted until the cycle after the B handshake. W before AW -> wready=0 until AW is accepted.
- Reset pulse during beat 2 of a len=7 burst -> all outputs return to reset values immediately; no bvalid; the next transaction completes normally with OKAY.
